// File: rtl/frame_sync_param.sv
// frame_sync_param: serial frame synchroniser with hunt/verify/lock/flywheel tracking.
//
// A SYNC_LEN-bit window (newest bit at the LSB, including the current input) is compared
// against SYNC_WORD. Up to MAX_ERR bit errors are tolerated. With INV_EN set, an inverted
// header is also accepted and the payload is inverted on the way out.
//
// Ports:
//   clk         - clock; one serial bit is sampled per rising edge
//   reset       - asynchronous, active-high reset
//   in          - serial data stream
//   out         - registered payload bit (polarity corrected)
//   out_enable  - out holds a valid payload bit
//   state       - 0 HUNT, 1 VERIFY, 2 LOCK, 3 FLYWHEEL
//   frame_start - one-cycle pulse alongside the first payload bit of each frame
//   polarity    - 1 when locked to the inverted header
//   hdr_errs    - bit-error count of the last accepted header
module frame_sync_param #(
   parameter logic [31:0] SYNC_WORD = 32'b10011011,
   parameter int unsigned SYNC_LEN  = 8,
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned CONFIRM_N = 3,
   parameter int unsigned LOSE_M    = 3,
   parameter int unsigned MAX_ERR   = 0,
   parameter int unsigned INV_EN    = 0,
   localparam int unsigned ErrW     = $clog2(SYNC_LEN + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in,
   output logic            out,
   output logic            out_enable,
   output logic [1:0]      state,
   output logic            frame_start,
   output logic            polarity,
   output logic [ErrW-1:0] hdr_errs
);

   localparam int unsigned PosW = $clog2(FRAME_LEN);
   localparam int unsigned HitW = $clog2(CONFIRM_N + 1);
   localparam int unsigned MisW = $clog2(LOSE_M + 1);

   localparam logic [1:0] StHunt   = 2'd0;
   localparam logic [1:0] StVerify = 2'd1;
   localparam logic [1:0] StLock   = 2'd2;
   localparam logic [1:0] StFly    = 2'd3;

   localparam logic [SYNC_LEN-1:0] SyncTrue = SYNC_WORD[SYNC_LEN-1:0];
   localparam logic [SYNC_LEN-1:0] SyncInv  = ~SyncTrue;
   localparam logic [PosW-1:0]     PosLast  = PosW'(FRAME_LEN - 1);
   localparam logic [PosW-1:0]     PayLast  = PosW'(FRAME_LEN - SYNC_LEN);
   localparam logic [PosW-1:0]     PosOne   = PosW'(1);
   localparam logic [ErrW-1:0]     MaxErr   = ErrW'(MAX_ERR);
   localparam logic [HitW-1:0]     HitGoal  = HitW'(CONFIRM_N);
   localparam logic [MisW-1:0]     MisGoal  = MisW'(LOSE_M);

   logic [1:0]          state_q, state_d;
   logic [PosW-1:0]     pos_q, pos_d;
   logic [HitW-1:0]     hits_q, hits_d;
   logic [MisW-1:0]     misses_q, misses_d;
   logic [SYNC_LEN-1:0] shift_q, win;
   logic                pol_q, pol_d;
   logic [ErrW-1:0]     errs_q, errs_d;
   logic                out_q, out_d;
   logic                oe_q, oe_d;
   logic                fs_q, fs_d;

   logic [ErrW-1:0] err_t, err_i, err_lat;
   logic            match_t, match_i, hit_lat, chk_pt, go_hunt, pay_ok;

   // Compare window includes the bit arriving this cycle.
   assign win = {shift_q[SYNC_LEN-2:0], in};

   always_comb begin
      err_t = '0;
      err_i = '0;
      for (int i = 0; i < int'(SYNC_LEN); i++) begin
         err_t = err_t + ErrW'(win[i] ^ SyncTrue[i]);
         err_i = err_i + ErrW'(win[i] ^ SyncInv[i]);
      end
   end

   assign match_t = (err_t <= MaxErr);
   assign match_i = (INV_EN != 0) && (err_i <= MaxErr);
   assign chk_pt  = (pos_q == PosLast);
   // Once synchronised only the latched polarity counts as a header.
   assign hit_lat = pol_q ? match_i : match_t;
   assign err_lat = pol_q ? err_i : err_t;

   always_comb begin
      state_d  = state_q;
      hits_d   = hits_q;
      misses_d = misses_q;
      pol_d    = pol_q;
      errs_d   = errs_q;
      go_hunt  = 1'b0;
      pos_d    = chk_pt ? '0 : pos_q + PosOne;
      unique case (state_q)
         StHunt: begin
            if (match_t || match_i) begin
               pos_d   = '0;
               pol_d   = ~match_t;   // true header wins when both match
               hits_d  = HitW'(1);
               errs_d  = match_t ? err_t : err_i;
               state_d = (CONFIRM_N == 1) ? StLock : StVerify;
            end
         end
         StVerify: begin
            if (chk_pt) begin
               if (hit_lat) begin
                  errs_d = err_lat;
                  hits_d = hits_q + HitW'(1);
                  if (hits_d == HitGoal) state_d = StLock;
               end else begin
                  go_hunt = 1'b1;
               end
            end
         end
         StLock: begin
            if (chk_pt) begin
               if (hit_lat) begin
                  errs_d = err_lat;
               end else if (LOSE_M == 1) begin
                  go_hunt = 1'b1;
               end else begin
                  state_d  = StFly;
                  misses_d = MisW'(1);
               end
            end
         end
         StFly: begin
            if (chk_pt) begin
               if (hit_lat) begin
                  errs_d   = err_lat;
                  state_d  = StLock;
                  misses_d = '0;
               end else begin
                  misses_d = misses_q + MisW'(1);
                  if (misses_d == MisGoal) go_hunt = 1'b1;
               end
            end
         end
         default: state_d = StHunt;
      endcase
      if (go_hunt) begin
         state_d  = StHunt;
         hits_d   = '0;
         misses_d = '0;
         pol_d    = 1'b0;
      end
   end

   // Payload occupies next-pos 1..FRAME_LEN-SYNC_LEN; the rest of the frame is header.
   always_comb begin
      pay_ok = ((state_d == StLock) || (state_d == StFly)) &&
               (pos_d != '0) && (pos_d <= PayLast);
      out_d  = pay_ok & (in ^ pol_d);
      oe_d   = pay_ok;
      fs_d   = pay_ok && (pos_d == PosOne);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StHunt;
         pos_q    <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         shift_q  <= '0;
         pol_q    <= 1'b0;
         errs_q   <= '0;
         out_q    <= 1'b0;
         oe_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
         shift_q  <= win;
         pol_q    <= pol_d;
         errs_q   <= errs_d;
         out_q    <= out_d;
         oe_q     <= oe_d;
         fs_q     <= fs_d;
      end
   end

   assign out         = out_q;
   assign out_enable  = oe_q;
   assign state       = state_q;
   assign frame_start = fs_q;
   assign polarity    = pol_q;
   assign hdr_errs    = errs_q;

endmodule

// File: tb/tb_frame_sync_param.sv
// tb_frame_sync_param: three instances share one serial stream:
//   u0 defaults, u1 MAX_ERR=1, u2 INV_EN=1.
// Each table row is one 256-bit frame (8-bit header + 248 payload bits) with the states
// expected right after its header. Payload bits expected on out are queued as they are
// driven and popped whenever the selected instance raises out_enable.
module tb_frame_sync_param;

   localparam logic [7:0] HdrT  = 8'b10011011;
   localparam logic [7:0] HdrI  = 8'b01100100;
   localparam logic [7:0] HdrZ  = 8'b00000000;
   localparam logic [7:0] HdrE1 = 8'b10011010;
   localparam logic [7:0] HdrE2 = 8'b10011000;
   localparam int PayLen = 248;

   typedef struct {
      logic [7:0] hdr;
      logic       pay;
      logic [1:0] st0;
      logic [1:0] st1;
      logic [1:0] st2;
      logic       chk1;
      logic [3:0] errs1;
      logic       pol2;
      logic       oe;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in;
   logic [2:0] out_w, oe_w, fs_w, pol_w;
   logic [1:0] st_w [3];
   logic [3:0] he_w [3];

   int   errors = 0;
   int   checks = 0;
   int   sb_sel = 0;
   logic exp_q[$];
   logic exp_bit;
   vec_t rows [20];

   always #5 clk = ~clk;

   frame_sync_param u0 (
      .clk(clk), .reset(reset), .in(in), .out(out_w[0]), .out_enable(oe_w[0]),
      .state(st_w[0]), .frame_start(fs_w[0]), .polarity(pol_w[0]), .hdr_errs(he_w[0])
   );
   frame_sync_param #(.MAX_ERR(1)) u1 (
      .clk(clk), .reset(reset), .in(in), .out(out_w[1]), .out_enable(oe_w[1]),
      .state(st_w[1]), .frame_start(fs_w[1]), .polarity(pol_w[1]), .hdr_errs(he_w[1])
   );
   frame_sync_param #(.INV_EN(1)) u2 (
      .clk(clk), .reset(reset), .in(in), .out(out_w[2]), .out_enable(oe_w[2]),
      .state(st_w[2]), .frame_start(fs_w[2]), .polarity(pol_w[2]), .hdr_errs(he_w[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      if (oe_w[sb_sel] === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("out_enable_extra", 32'(oe_w[sb_sel]), 32'd0);
         end else begin
            exp_bit = exp_q.pop_front();
            check("payload_out", 32'(out_w[sb_sel]), 32'(exp_bit));
         end
      end
   end

   // Present a bit, let the next rising edge take it, return 1 time unit after that edge.
   task automatic drive_bit(input logic b, input logic push, input logic pol);
      in = b;
      if (push) exp_q.push_back(b ^ pol);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 3; d++)
         check($sformatf("%s_dut%0d", tag, d),
               32'({st_w[d], out_w[d], oe_w[d], fs_w[d], pol_w[d], he_w[d]}), 32'd0);
   endtask

   task automatic send_row(input int idx);
      vec_t r;
      logic p;
      r = rows[idx];
      p = (sb_sel == 2) ? r.pol2 : 1'b0;
      for (int i = 7; i >= 0; i--) drive_bit(r.hdr[i], 1'b0, 1'b0);
      check($sformatf("row%0d_state0", idx), 32'(st_w[0]), 32'(r.st0));
      check($sformatf("row%0d_state2", idx), 32'(st_w[2]), 32'(r.st2));
      check($sformatf("row%0d_polarity2", idx), 32'(pol_w[2]), 32'(r.pol2));
      check($sformatf("row%0d_sb_empty", idx), 32'(exp_q.size()), 32'd0);
      if (r.chk1) begin
         check($sformatf("row%0d_state1", idx), 32'(st_w[1]), 32'(r.st1));
         check($sformatf("row%0d_hdr_errs1", idx), 32'(he_w[1]), 32'(r.errs1));
      end
      for (int j = 0; j < PayLen; j++) begin
         drive_bit(r.pay, r.oe, p);
         if (j == 0) begin
            check($sformatf("row%0d_oe_first", idx), 32'(oe_w[sb_sel]), 32'(r.oe));
            check($sformatf("row%0d_frame_start", idx), 32'(fs_w[sb_sel]), 32'(r.oe));
         end else if (j == 1) begin
            check($sformatf("row%0d_frame_start_end", idx), 32'(fs_w[sb_sel]), 32'd0);
         end
      end
   endtask

   initial begin
      //           hdr    pay   st0   st1   st2  chk1 errs1 pol2  oe
      rows[0]  = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[1]  = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[2]  = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[3]  = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[4]  = '{HdrZ,  1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[5]  = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[6]  = '{HdrE1, 1'b0, 2'd3, 2'd2, 2'd3, 1'b1, 4'd1, 1'b0, 1'b1};
      rows[7]  = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[8]  = '{HdrE2, 1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[9]  = '{HdrZ,  1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[10] = '{HdrZ,  1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[11] = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[12] = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[13] = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[14] = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[15] = '{HdrT,  1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0};
      rows[16] = '{HdrT,  1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
      rows[17] = '{HdrI,  1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b1, 1'b0};
      rows[18] = '{HdrI,  1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b1, 1'b0};
      rows[19] = '{HdrI,  1'b1, 2'd0, 2'd0, 2'd2, 1'b0, 4'd0, 1'b1, 1'b1};

      reset = 1'b1;
      in    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      reset = 1'b0;

      // Acquire, flywheel, error tolerance, loss of lock, relock.
      for (int k = 0; k <= 13; k++) send_row(k);

      // Reset in the middle of a locked payload.
      for (int i = 7; i >= 0; i--) drive_bit(HdrT[i], 1'b0, 1'b0);
      check("midreset_locked", 32'(st_w[0]), 32'd2);
      for (int j = 0; j < 100; j++) drive_bit(1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_all_zero("midreset_during");
      repeat (3) drive_bit(1'b1, 1'b0, 1'b0);
      check_all_zero("midreset_held");
      reset = 1'b0;
      drive_bit(1'b0, 1'b0, 1'b0);
      check("midreset_release_state", 32'(st_w[0]), 32'd0);
      check("midreset_release_oe", 32'(oe_w[0]), 32'd0);
      repeat (20) drive_bit(1'b0, 1'b0, 1'b0);
      for (int k = 14; k <= 16; k++) send_row(k);
      repeat (2) drive_bit(1'b0, 1'b0, 1'b0);
      check("drain_true", 32'(exp_q.size()), 32'd0);

      // Inverted-header stream: u2 locks inverted, u0 never leaves HUNT.
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_all_zero("phase_b_reset");
      repeat (2) drive_bit(1'b0, 1'b0, 1'b0);
      reset  = 1'b0;
      sb_sel = 2;
      for (int k = 17; k <= 19; k++) send_row(k);
      repeat (2) drive_bit(1'b1, 1'b0, 1'b0);
      check("drain_inv", 32'(exp_q.size()), 32'd0);
      check("inv_final_state0", 32'(st_w[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
